mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-CPU icache/dcache arbiter onto one RAM port; ports: CLK/nRST, i*/d* cache sides, ram* RAM side, err_count
module mem_arbiter #(
  parameter int NCPUS    = 2,
  parameter int MAXBURST = 4
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [NCPUS-1:0]            iREN,
  input  logic [NCPUS-1:0][31:0]      iaddr,
  input  logic [NCPUS-1:0]            dREN,
  input  logic [NCPUS-1:0]            dWEN,
  input  logic [NCPUS-1:0][31:0]      daddr,
  input  logic [NCPUS-1:0][31:0]      dstore,
  output logic [NCPUS-1:0]            iwait,
  output logic [NCPUS-1:0]            dwait,
  output logic [NCPUS-1:0][31:0]      iload,
  output logic [NCPUS-1:0][31:0]      dload,
  output logic                        ramREN,
  output logic                        ramWEN,
  output logic [31:0]                 ramaddr,
  output logic [31:0]                 ramstore,
  input  logic [31:0]                 ramload,
  input  logic [1:0]                  ramstate,
  output logic [7:0]                  err_count
);
  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;
  state_t state, state_n;
  logic gcpu, gcpu_n, drr, drr_n, irr, irr_n;
  logic [3:0] bcnt, bcnt_n;
  logic [7:0] err_n;
  logic [NCPUS-1:0] dreq, gsel;
  logic acc, greq, others, rel;
  assign iload = {NCPUS{ramload}};
  assign dload = {NCPUS{ramload}};
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) begin
      state     <= IDLE;
      gcpu      <= 1'b0;
      drr       <= 1'b0;
      irr       <= 1'b0;
      bcnt      <= '0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      gcpu      <= gcpu_n;
      drr       <= drr_n;
      irr       <= irr_n;
      bcnt      <= bcnt_n;
      err_count <= err_n;
    end
  always_comb begin
    dreq     = dREN | dWEN;
    acc      = ramstate == 2'd2;
    gsel     = NCPUS'(1) << gcpu;
    greq     = state == DGRANT ? dreq[gcpu] : state == IGRANT ? iREN[gcpu] : 1'b0;
    // any requester other than the one currently holding the grant
    others   = |(dreq & ~(state == DGRANT ? gsel : '0)) | |(iREN & ~(state == IGRANT ? gsel : '0));
    rel      = !greq || (acc && ({1'b0, bcnt} + 5'd1 >= 5'(MAXBURST)) && others);
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    state_n  = state;
    gcpu_n   = gcpu;
    drr_n    = drr;
    irr_n    = irr;
    bcnt_n   = bcnt;
    err_n    = (state != IDLE && ramstate == 2'd3 && err_count != 8'hff) ? err_count + 8'd1 : err_count;
    if (state == DGRANT) begin
      ramaddr     = daddr[gcpu];
      ramWEN      = dWEN[gcpu];
      ramREN      = dREN[gcpu] & ~dWEN[gcpu];
      ramstore    = dWEN[gcpu] ? dstore[gcpu] : '0;
      dwait[gcpu] = !(acc && dreq[gcpu]);
    end else if (state == IGRANT) begin
      ramaddr     = iaddr[gcpu];
      ramREN      = iREN[gcpu];
      iwait[gcpu] = !(acc && iREN[gcpu]);
    end
    if (state == IDLE) begin
      // dcache beats icache; on a tie the class pointer picks, else the lone requester (bit 1 set means CPU1)
      if (|dreq) begin
        state_n = DGRANT;
        gcpu_n  = &dreq ? drr : dreq[1];
        bcnt_n  = '0;
      end else if (|iREN) begin
        state_n = IGRANT;
        gcpu_n  = &iREN ? irr : iREN[1];
        bcnt_n  = '0;
      end
    end else begin
      bcnt_n = (acc && bcnt != 4'hf) ? bcnt + 4'd1 : bcnt;
      if (rel) begin
        state_n = IDLE;
        drr_n   = state == DGRANT ? !gcpu : drr;
        irr_n   = state == IGRANT ? !gcpu : irr;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic CLK = 1'b0, nRST = 1'b0;
  logic [1:0] iREN = '0, dREN = '0, dWEN = '0, iwait, dwait;
  logic [1:0][31:0] iaddr = '0, daddr = '0, dstore = '0, iload, dload;
  logic ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload = '0;
  logic [1:0] ramstate = '0;
  logic [7:0] err_count;
  int n_chk = 0, n_fail = 0;
  mem_arbiter #(.NCPUS(2), .MAXBURST(4)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err_count(err_count)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask
  task automatic mid;
    @(negedge CLK);
  endtask
  initial begin
    #12;
    check("rst_ren", 32'(ramREN), 0);
    check("rst_iwait", 32'(iwait), 3);
    check("rst_dwait", 32'(dwait), 3);
    check("rst_err", 32'(err_count), 0);
    nRST = 1'b1;
    cyc;
    // single icache read, two BUSY then ACCESS
    iREN = 2'b01; iaddr[0] = 32'h40; mid;
    check("rd_idle_ren", 32'(ramREN), 0);
    cyc; ramstate = 2'd1; mid;
    check("rd_c1_ren", 32'(ramREN), 1);
    check("rd_c1_addr", ramaddr, 32'h40);
    check("rd_c1_iwait", 32'(iwait), 3);
    cyc; mid;
    check("rd_c2_iwait", 32'(iwait), 3);
    cyc; ramstate = 2'd2; ramload = 32'hDEADBEEF; mid;
    check("rd_c3_iwait", 32'(iwait), 2);
    check("rd_c3_iload", iload[0], 32'hDEADBEEF);
    check("rd_c3_dload", dload[1], 32'hDEADBEEF);
    cyc; iREN = '0; ramstate = 2'd0; mid;
    check("rd_drop_ren", 32'(ramREN), 0);
    cyc;
    // dcache beats icache
    iREN = 2'b10; iaddr[1] = 32'h200; dREN = 2'b01; daddr[0] = 32'h100; mid;
    check("pri_idle_ren", 32'(ramREN), 0);
    cyc; ramstate = 2'd1; mid;
    check("pri_d_ren", 32'(ramREN), 1);
    check("pri_d_addr", ramaddr, 32'h100);
    check("pri_d_wen", 32'(ramWEN), 0);
    cyc; ramstate = 2'd2; mid;
    check("pri_d_dwait", 32'(dwait), 2);
    check("pri_d_iwait", 32'(iwait), 3);
    cyc; dREN = '0; ramstate = 2'd0; mid;
    check("pri_d_hold_addr", ramaddr, 32'h100);
    cyc; mid;
    check("pri_gap_ren", 32'(ramREN), 0);
    check("pri_gap_addr", ramaddr, 0);
    cyc; mid;
    check("pri_i_ren", 32'(ramREN), 1);
    check("pri_i_addr", ramaddr, 32'h200);
    cyc; ramstate = 2'd2; mid;
    check("pri_i_iwait", 32'(iwait), 1);
    cyc; iREN = '0; ramstate = 2'd0;
    cyc;
    // fresh pointers, then dcache round-robin with single-cycle ACCESS
    nRST = 1'b0; #1; nRST = 1'b1;
    cyc;
    dREN = 2'b11; daddr[0] = 32'hA0; daddr[1] = 32'hB0; ramstate = 2'd2; mid;
    check("rr_idle_ren", 32'(ramREN), 0);
    for (int g = 0; g < 3; g++) begin
      for (int w = 0; w < 4; w++) begin
        cyc; mid;
        check($sformatf("rr_g%0d_w%0d_addr", g, w), ramaddr, (g % 2) ? 32'hB0 : 32'hA0);
        check($sformatf("rr_g%0d_w%0d_dwait", g, w), 32'(dwait), (g % 2) ? 1 : 2);
      end
      cyc;
      if (g == 2) dREN = '0;
      mid;
      check($sformatf("rr_gap%0d_ren", g), 32'(ramREN), 0);
      check($sformatf("rr_gap%0d_dwait", g), 32'(dwait), 3);
    end
    cyc;
    // writeback then fetch under one grant
    dWEN = 2'b01; dREN = 2'b01; daddr[0] = 32'h10; dstore[0] = 32'h11; mid;
    check("bl_idle_wen", 32'(ramWEN), 0);
    cyc; mid;
    check("bl_w0_wen", 32'(ramWEN), 1);
    check("bl_w0_ren", 32'(ramREN), 0);
    check("bl_w0_addr", ramaddr, 32'h10);
    check("bl_w0_store", ramstore, 32'h11);
    check("bl_w0_dwait", 32'(dwait), 2);
    cyc; dREN = '0; daddr[0] = 32'h14; dstore[0] = 32'h22; mid;
    check("bl_w1_addr", ramaddr, 32'h14);
    check("bl_w1_store", ramstore, 32'h22);
    cyc; dWEN = '0; dREN = 2'b01; daddr[0] = 32'h18; mid;
    check("bl_r0_ren", 32'(ramREN), 1);
    check("bl_r0_wen", 32'(ramWEN), 0);
    check("bl_r0_addr", ramaddr, 32'h18);
    cyc; daddr[0] = 32'h1C; mid;
    check("bl_r1_ren", 32'(ramREN), 1);
    check("bl_r1_addr", ramaddr, 32'h1C);
    check("bl_r1_dwait", 32'(dwait), 2);
    cyc; dREN = '0; ramstate = 2'd0; mid;
    check("bl_drop_ren", 32'(ramREN), 0);
    cyc;
    // ERROR behaves as BUSY and is counted only while granted
    dREN = 2'b10; daddr[1] = 32'h300; ramstate = 2'd3; mid;
    for (int c = 0; c < 3; c++) begin
      cyc; mid;
      check($sformatf("err_c%0d_dwait", c), 32'(dwait), 3);
      check($sformatf("err_c%0d_ren", c), 32'(ramREN), 1);
    end
    cyc; ramstate = 2'd2; mid;
    check("err_done_dwait", 32'(dwait), 1);
    check("err_count", 32'(err_count), 3);
    cyc; dREN = '0; ramstate = 2'd0;
    cyc;
    // asynchronous reset mid-grant
    dWEN = 2'b01; daddr[0] = 32'h500; dstore[0] = 32'h55; ramstate = 2'd1;
    cyc; mid;
    check("ar_pre_wen", 32'(ramWEN), 1);
    #2 nRST = 1'b0;
    #1;
    check("ar_wen", 32'(ramWEN), 0);
    check("ar_ren", 32'(ramREN), 0);
    check("ar_dwait", 32'(dwait), 3);
    check("ar_iwait", 32'(iwait), 3);
    check("ar_err", 32'(err_count), 0);
    cyc; nRST = 1'b1;
    cyc; mid;
    check("ar_regrant_wen", 32'(ramWEN), 1);
    check("ar_regrant_addr", ramaddr, 32'h500);
    dWEN = '0;
    cyc; cyc;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
